tone_gen: RTL and testbench

Parametrised multi-channel test-tone generator, successor to the single-channel sawtooth test tone. Each channel has its own phase accumulator, waveform select, attenuation and pan. Channels are processed one per clock after each sample request and mixed into a saturated stereo sample. It sits between the audio sample-rate timing (which issues `i_sample_req`) and the audio output path / I2S serializer, and serves as a bring-up and loopback stimulus source.

---
 rtl/tone_pkg.sv | 27 ++
 rtl/tone_wave_shaper.sv | 32 +++
 rtl/tone_gen.sv | 137 +++++++++++++
 tb/tb_tone_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types and saturation helper for the tone generator
package tone_pkg;

    typedef enum logic [1:0] {
        SAW    = 2'b00,
        SQUARE = 2'b01,
        TRI    = 2'b10,
        SILENT = 2'b11
    } wave_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OUT  = 2'b10
    } state_e;

    // Returns {over, under} for a signed value against a w-bit signed range.
    // Callers keep the low w bits when neither flag is set.
    function automatic logic [1:0] sat_flags(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        sat_flags = {v > hi, v < lo};
    endfunction

endpackage

// File: rtl/tone_wave_shaper.sv
// rtl/tone_wave_shaper.sv - maps phase, waveform select and level to an attenuated sample
module tone_wave_shaper
    import tone_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0]        p,
    input  logic [1:0]                 wave,
    input  logic [2:0]                 level,
    output logic signed [SAMPLE_W-1:0] w
);

    localparam int MSB = SAMPLE_W - 1;

    logic signed [SAMPLE_W-1:0] raw;
    logic [SAMPLE_W-1:0]        fold;

    // Build the full-scale waveform, then attenuate with an arithmetic shift
    always_comb begin
        raw  = '0;
        fold = (p[MSB] ? ~p : p) << 1;
        case (wave_e'(wave))
            SAW:     raw = {~p[MSB], p[MSB-1:0]};
            SQUARE:  raw = p[MSB] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                  : {1'b0, {(SAMPLE_W-1){1'b1}}};
            TRI:     raw = {~fold[MSB], fold[MSB-1:0]};
            default: raw = '0;
        endcase
        w = raw >>> level;
    end

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - multi-channel test-tone generator with saturated stereo mix
module tone_gen
    import tone_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 24,
    parameter int FCW_W    = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH*FCW_W-1:0] i_fcw,
    input  logic [NUM_CH*2-1:0]     i_wave,
    input  logic [NUM_CH*3-1:0]     i_level,
    input  logic [NUM_CH*2-1:0]     i_pan,
    input  logic                    i_phase_clr,
    input  logic                    i_sample_req,
    output logic [2*SAMPLE_W-1:0]   o_sample,
    output logic                    o_valid,
    output logic                    o_busy
);

    localparam int MIX_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e state_q, state_d;

    logic [ACC_W-1:0]        acc [NUM_CH];
    logic [CH_W-1:0]         ch;
    logic signed [MIX_W-1:0] sum_l, sum_r;

    logic [FCW_W-1:0]           cur_fcw;
    logic [1:0]                 cur_wave;
    logic [2:0]                 cur_level;
    logic [1:0]                 cur_pan;
    logic [SAMPLE_W-1:0]        cur_p;
    logic signed [SAMPLE_W-1:0] cur_w;
    logic signed [MIX_W-1:0]    cur_w_ext;
    logic [1:0]                 sat_l, sat_r;
    logic [SAMPLE_W-1:0]        out_l, out_r;

    localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Select the configuration and pre-update phase of the channel being processed
    always_comb begin
        cur_fcw   = i_fcw[ch*FCW_W +: FCW_W];
        cur_wave  = i_wave[ch*2 +: 2];
        cur_level = i_level[ch*3 +: 3];
        cur_pan   = i_pan[ch*2 +: 2];
        cur_p     = acc[ch][ACC_W-1 -: SAMPLE_W];
    end

    tone_wave_shaper #(
        .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
        .p     (cur_p),
        .wave  (cur_wave),
        .level (cur_level),
        .w     (cur_w)
    );

    assign cur_w_ext = {{(MIX_W-SAMPLE_W){cur_w[SAMPLE_W-1]}}, cur_w};

    // Clamp both mix sums to the output range
    always_comb begin
        sat_l = sat_flags(32'(sum_l), SAMPLE_W);
        sat_r = sat_flags(32'(sum_r), SAMPLE_W);
        out_l = sat_l[1] ? S_MAX : (sat_l[0] ? S_MIN : sum_l[SAMPLE_W-1:0]);
        out_r = sat_r[1] ? S_MAX : (sat_r[0] ? S_MIN : sum_r[SAMPLE_W-1:0]);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept a request, walk all channels, then publish
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_sample_req) state_d = RUN;
            RUN:     if (ch == LAST_CH) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

    // Accumulators, channel counter, mix sums and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                acc[n] <= '0;
            end
            ch       <= '0;
            sum_l    <= '0;
            sum_r    <= '0;
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_phase_clr) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                            acc[n] <= '0;
                        end
                    end
                    if (i_sample_req) begin
                        ch    <= '0;
                        sum_l <= '0;
                        sum_r <= '0;
                    end
                end
                RUN: begin
                    if (cur_pan[1]) sum_l <= sum_l + cur_w_ext;
                    if (cur_pan[0]) sum_r <= sum_r + cur_w_ext;
                    acc[ch] <= acc[ch] + ACC_W'(cur_fcw);
                    ch      <= ch + 1'b1;
                end
                OUT: begin
                    o_sample <= {out_l, out_r};
                    o_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed self-checking bench for tone_gen
module tb_tone_gen;

    localparam int NUM_CH   = 4;
    localparam int ACC_W    = 24;
    localparam int FCW_W    = 16;
    localparam int SAMPLE_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*FCW_W-1:0] fcw;
    logic [NUM_CH*2-1:0]     wave;
    logic [NUM_CH*3-1:0]     level;
    logic [NUM_CH*2-1:0]     pan;
    logic                    phase_clr;
    logic                    req;
    logic [2*SAMPLE_W-1:0]   sample;
    logic                    valid;
    logic                    busy;

    int checks   = 0;
    int failures = 0;

    tone_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .FCW_W    (FCW_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fcw        (fcw),
        .i_wave       (wave),
        .i_level      (level),
        .i_pan        (pan),
        .i_phase_clr  (phase_clr),
        .i_sample_req (req),
        .o_sample     (sample),
        .o_valid      (valid),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_silent();
        fcw   = '0;
        wave  = '1;
        level = '0;
        pan   = '0;
    endtask

    task automatic set_ch(input int n, input logic [15:0] f, input logic [1:0] wv,
                          input logic [2:0] lv, input logic [1:0] pn);
        fcw[n*FCW_W +: FCW_W] = f;
        wave[n*2 +: 2]        = wv;
        level[n*3 +: 3]       = lv;
        pan[n*2 +: 2]         = pn;
    endtask

    // One request (optionally with phase clear); returns sample and edges to o_valid
    task automatic run_req(input logic clr, output logic [31:0] s, output int lat);
        @(negedge clk);
        req       = 1'b1;
        phase_clr = clr;
        @(negedge clk);
        req       = 1'b0;
        phase_clr = 1'b0;
        lat       = 1;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sample;
    endtask

    logic [31:0] s;
    int          lat;
    int          nv;
    logic [23:0] acc_m;
    logic [15:0] p, t, e;

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        phase_clr = 1'b0;
        all_silent();

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_sample", sample, 32'h0);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);

        // ch0 saw, exact latency and one-step advance
        set_ch(0, 16'h0100, 2'b00, 3'd0, 2'b11);
        run_req(1'b0, s, lat);
        check("saw_latency", lat, 6);
        check("saw_req1", s, 32'h8000_8000);
        @(negedge clk);
        check("valid_pulse_width", valid, 1'b0);
        run_req(1'b0, s, lat);
        check("saw_req2", s, 32'h8001_8001);

        // Reset mid-run abandons the sample and zeroes the phase
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("busy_in_run", busy, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("busy_in_reset", busy, 1'b0);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("no_valid_after_abort", nv, 0);
        run_req(1'b0, s, lat);
        check("post_reset_phase0", s, 32'h8000_8000);

        // Four squares at phase 0 saturate; level 2 fits
        for (int n = 0; n < NUM_CH; n++) set_ch(n, 16'h0000, 2'b01, 3'd0, 2'b11);
        run_req(1'b1, s, lat);
        check("square_sat", s, 32'h7FFF_7FFF);
        for (int n = 0; n < NUM_CH; n++) set_ch(n, 16'h0000, 2'b01, 3'd2, 2'b11);
        run_req(1'b0, s, lat);
        check("square_lvl2", s, 32'h7FFC_7FFC);

        // Pan routing
        all_silent();
        set_ch(0, 16'h0000, 2'b01, 3'd0, 2'b10);
        run_req(1'b0, s, lat);
        check("pan_left", s, 32'h7FFF_0000);
        set_ch(0, 16'h0000, 2'b01, 3'd0, 2'b01);
        run_req(1'b0, s, lat);
        check("pan_right", s, 32'h0000_7FFF);

        // Triangle sweep across the accumulator wrap
        all_silent();
        set_ch(0, 16'hFFFF, 2'b10, 3'd0, 2'b11);
        acc_m = 24'h0;
        for (int k = 0; k < 260; k++) begin
            run_req(k == 0, s, lat);
            p = acc_m[23:8];
            t = (p[15] ? ~p : p) << 1;
            e = t ^ 16'h8000;
            check($sformatf("tri_%0d", k), s, {e, e});
            acc_m = acc_m + 24'h00FFFF;
        end

        // Request during busy is dropped
        all_silent();
        set_ch(0, 16'h0100, 2'b00, 3'd0, 2'b11);
        run_req(1'b1, s, lat);
        check("dbl_setup", s, 32'h8000_8000);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        nv = 0;
        repeat (12) begin
            if (valid) begin
                nv++;
                s = sample;
            end
            @(negedge clk);
        end
        check("dbl_valid_count", nv, 1);
        check("dbl_sample", s, 32'h8001_8001);
        run_req(1'b0, s, lat);
        check("dbl_single_advance", s, 32'h8002_8002);

        // Phase clear together with request
        run_req(1'b1, s, lat);
        check("clr_with_req", s, 32'h8000_8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
